// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the instruction-fetch PC block.
package fetch_pc_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_pc_next_pc_calc.sv
// Control-transfer target and alignment check for the EX-stage instruction.
module next_pc_calc
   import fetch_pc_pkg::*;
(
   input  logic            is_jalr,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   logic [XLEN-1:0] jalr_sum;

   always_comb begin
      jalr_sum = rs1 + imm;
      if (is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
      else         target = ex_pc + imm;
      misaligned = (target[1:0] != 2'b00);
   end

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage PC sequencer: boot, sequential fetch, redirects and misalignment trap.
//
// state    | meaning
// ST_BOOT  | single idle cycle after reset release, no requests
// ST_FETCH | issuing fetches, accepting redirects from EX
// ST_TRAP  | misaligned target seen; frozen until reset
module fetch_pc
   import fetch_pc_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            is_branch,
   input  logic            is_jal,
   input  logic            is_jalr,
   input  logic            br_taken,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic            flush,
   output logic            misalign_exc,
   output logic [15:0]     redirect_cnt
);

   state_t          state, next_state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic            redirect;
   logic            good_redirect;
   logic            accept;

   next_pc_calc u_next_pc_calc (
      .is_jalr    (is_jalr),
      .ex_pc      (ex_pc),
      .imm        (imm),
      .rs1        (rs1),
      .target     (target),
      .misaligned (misaligned)
   );

   always_comb begin
      next_state    = state;
      imem_req      = 1'b0;
      flush         = 1'b0;
      misalign_exc  = 1'b0;
      redirect      = 1'b0;
      good_redirect = 1'b0;
      case (state)
         ST_BOOT: next_state = ST_FETCH;
         ST_FETCH: begin
            redirect = (is_branch & br_taken) | is_jal | is_jalr;
            if (redirect) begin
               flush = 1'b1;
               if (misaligned) begin
                  misalign_exc = 1'b1;
                  next_state   = ST_TRAP;
               end else begin
                  good_redirect = 1'b1;
               end
            end else begin
               imem_req = ~stall;
            end
         end
         ST_TRAP: next_state = ST_TRAP;
         default: next_state = ST_BOOT;
      endcase
   end

   assign accept    = imem_req & imem_ready;
   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_BOOT;
         pc           <= RESET_PC;
         if_valid     <= 1'b0;
         if_pc        <= '0;
         redirect_cnt <= '0;
      end else begin
         state <= next_state;

         if (good_redirect)  pc <= target;
         else if (accept)    pc <= pc + XLEN'(INSTR_BYTES);

         // Stall only freezes the IF register while actually fetching.
         if (state != ST_FETCH || redirect) begin
            if_valid <= 1'b0;
         end else if (accept) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
         end else if (!stall) begin
            if_valid <= 1'b0;
         end

         if (good_redirect && redirect_cnt != 16'hFFFF)
            redirect_cnt <= redirect_cnt + 16'd1;
      end
   end

endmodule

// File: doc/fetch_pc.md
FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of first fetch after reset.
REQ-002 Ports: one clock, clk; reset rst is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 stall  in  1  hazard hold; freezes PC and IF outputs.
REQ-006 is_branch/is_jal/is_jalr  in  1 each  EX-stage control-transfer type, mutually exclusive.
REQ-007 br_taken  in  1  branch comparator result for the EX instruction.
REQ-008 ex_pc  in  32  PC of EX instruction; imm  in  32  sign-extended immediate; rs1  in  32  jalr base.
REQ-009 imem_req  out  1 / imem_addr  out  32  fetch request/address; imem_ready  in  1  same-cycle accept.
REQ-010 if_valid  out  1 / if_pc  out  32  registered fetched-instruction tag to decode.
REQ-011 flush  out  1  kill younger instructions; misalign_exc  out  1  one-cycle trap pulse.
REQ-012 redirect_cnt  out  16  saturating count of taken redirects.

Function
REQ-013 States: BOOT, FETCH, TRAP; BOOT lasts exactly one cycle after reset release, then FETCH.
REQ-014 redirect = (is_branch & br_taken) | is_jal | is_jalr, evaluated only in FETCH.
REQ-015 Target: branch/jal = ex_pc + imm; jalr = (rs1 + imm) & ~32'h1; all sums modulo 2^32 (wrap, no overflow flag).
REQ-016 Target with bits [1:0] != 0: misalign_exc = 1 for that cycle, no PC update, flush = 1, next state TRAP.
REQ-017 TRAP is absorbing until rst; imem_req = 0, if_valid = 0, redirect ignored.
REQ-018 imem_req = (state == FETCH) & ~stall & ~redirect; imem_addr = pc at all times.
REQ-019 Accept = imem_req & imem_ready; on accept: pc <= pc + 4, if_valid <= 1, if_pc <= pc.
REQ-020 Aligned redirect: flush = 1 combinationally same cycle, pc <= target, if_valid <= 0; overrides stall and any pending accept.
REQ-021 stall without redirect: pc, if_valid, if_pc hold.
REQ-022 No accept, no stall, no redirect: if_valid <= 0, pc holds.
REQ-023 redirect_cnt increments on each aligned redirect, saturates at 16'hFFFF.
REQ-024 pc + 4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.

Reset
REQ-025 rst asserted: state = BOOT, pc = RESET_PC, if_valid = 0, if_pc = 0, redirect_cnt = 0, immediately (asynchronous).
REQ-026 During BOOT: imem_req = 0, flush = 0, misalign_exc = 0.
REQ-027 rst mid-fetch or in TRAP discards the outstanding request; no accept counted.

Structure
REQ-028 Shared package holds the state enum type, XLEN = 32, INSTR_BYTES = 4, and the RESET_PC default value.
REQ-029 One combinational sub-module next_pc_calc computes target and misalignment; FSM, PC register and counter stay in fetch_pc.

Verification
REQ-030 Reset release, imem_ready = 1 constant -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles after BOOT; if_pc trails by one cycle.
REQ-031 ex_pc = 0x100, imm = 0x20, is_branch = 1, br_taken = 1, simultaneous stall = 1 -> flush = 1, next imem_addr = 0x120, redirect_cnt = 1.
REQ-032 is_jalr = 1, rs1 = 0x2001, imm = 0x3 -> target 0x2004 (bit0 cleared), no exception.
REQ-033 is_jal = 1, ex_pc = 0x10, imm = 0x6 -> misalign_exc pulse 1 cycle, state TRAP, imem_req stays 0 until rst.
REQ-034 pc = 0xFFFF_FFFC accepted -> next imem_addr = 0x0; stall = 1 for 3 cycles -> imem_req = 0, if_pc/if_valid frozen.
REQ-035 Force redirect_cnt to 0xFFFF via 65535 jals, one more jal -> remains 0xFFFF.
